// File: rtl/trigger_divider_ctrl.sv
// Run-time controller for the trigger clock divider: programmable half-period divided clock
// with start/stop, finite bursts and glitch-free factor updates at period boundaries.
module trigger_divider_ctrl #(
  parameter int WIDTH          = 8,
  parameter int DEFAULT_FACTOR = 5,
  parameter int CNT_W          = 16
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cfg_factor,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic             start,
  input  logic             stop,
  input  logic [CNT_W-1:0] burst_len,
  output logic             clk_out,
  output logic             tick,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] factor_active
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_nx;
  logic             clk_out_nx, tick_nx, busy_nx, done_nx, cfg_ready_nx;
  logic [WIDTH-1:0] factor_nx, cnt, cnt_nx, pend_factor, pend_factor_nx;
  logic             pend_vld, pend_vld_nx, stop_pend, stop_pend_nx;
  logic [CNT_W-1:0] remaining, remaining_nx;
  logic             cfg_nz, phase_end, finish;

  always_comb begin
    state_nx       = state;
    clk_out_nx     = clk_out;
    tick_nx        = 1'b0;
    busy_nx        = busy;
    done_nx        = 1'b0;
    cfg_ready_nx   = cfg_ready;
    factor_nx      = factor_active;
    cnt_nx         = cnt;
    pend_factor_nx = pend_factor;
    pend_vld_nx    = pend_vld;
    stop_pend_nx   = stop_pend;
    remaining_nx   = remaining;

    // A zero factor completes the handshake but is otherwise dropped.
    cfg_nz    = cfg_valid && cfg_ready && (cfg_factor != '0);
    phase_end = (cnt == factor_active);
    finish    = stop_pend || stop || (remaining == CNT_W'(1));

    case (state)
      IDLE: begin
        if (cfg_nz) factor_nx = cfg_factor;
        if (start && !stop && !done) begin
          state_nx     = RUN;
          clk_out_nx   = 1'b1;
          tick_nx      = 1'b1;
          busy_nx      = 1'b1;
          cnt_nx       = WIDTH'(1);
          remaining_nx = burst_len;
          stop_pend_nx = 1'b0;
        end
      end
      RUN: begin
        if (stop) stop_pend_nx = 1'b1;
        if (cfg_nz) begin
          pend_vld_nx    = 1'b1;
          pend_factor_nx = cfg_factor;
          cfg_ready_nx   = 1'b0;
        end
        if (!phase_end) begin
          cnt_nx = cnt + WIDTH'(1);
        end else begin
          cnt_nx = WIDTH'(1);
          if (clk_out) begin
            clk_out_nx = 1'b0;
          end else if (finish) begin
            // Run ends on a low phase, so clk_out is already 0 here.
            state_nx     = IDLE;
            done_nx      = 1'b1;
            busy_nx      = 1'b0;
            stop_pend_nx = 1'b0;
            pend_vld_nx  = 1'b0;
            cfg_ready_nx = 1'b1;
            if (pend_vld)    factor_nx = pend_factor;
            else if (cfg_nz) factor_nx = cfg_factor;
          end else begin
            if (remaining != '0) remaining_nx = remaining - CNT_W'(1);
            clk_out_nx = 1'b1;
            tick_nx    = 1'b1;
            if (pend_vld) begin
              factor_nx    = pend_factor;
              pend_vld_nx  = 1'b0;
              cfg_ready_nx = 1'b1;
            end
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      clk_out       <= 1'b0;
      tick          <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      cfg_ready     <= 1'b1;
      factor_active <= WIDTH'(DEFAULT_FACTOR);
      cnt           <= '0;
      pend_factor   <= '0;
      pend_vld      <= 1'b0;
      stop_pend     <= 1'b0;
      remaining     <= '0;
    end else begin
      state         <= state_nx;
      clk_out       <= clk_out_nx;
      tick          <= tick_nx;
      busy          <= busy_nx;
      done          <= done_nx;
      cfg_ready     <= cfg_ready_nx;
      factor_active <= factor_nx;
      cnt           <= cnt_nx;
      pend_factor   <= pend_factor_nx;
      pend_vld      <= pend_vld_nx;
      stop_pend     <= stop_pend_nx;
      remaining     <= remaining_nx;
    end
  end

endmodule

// File: tb/tb_trigger_divider_ctrl.sv
// Scoreboard bench for trigger_divider_ctrl: directed runs push expected tick/fall/done
// events with hand-computed cycle numbers; a negedge monitor pops and compares them.
module tb_trigger_divider_ctrl;
  localparam int WIDTH = 8;
  localparam int CNT_W = 16;

  logic             clk_in, rst_n;
  logic [WIDTH-1:0] cfg_factor;
  logic             cfg_valid, cfg_ready;
  logic             start, stop;
  logic [CNT_W-1:0] burst_len;
  logic             clk_out, tick, busy, done;
  logic [WIDTH-1:0] factor_active;

  trigger_divider_ctrl #(.WIDTH(WIDTH), .DEFAULT_FACTOR(5), .CNT_W(CNT_W)) dut (
    .clk_in(clk_in), .rst_n(rst_n), .cfg_factor(cfg_factor), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .start(start), .stop(stop), .burst_len(burst_len),
    .clk_out(clk_out), .tick(tick), .busy(busy), .done(done), .factor_active(factor_active)
  );

  // kind: 0 = tick (rising edge), 1 = clk_out falling edge, 2 = done pulse
  typedef struct { int kind; int cyc; int fac; } ev_t;
  ev_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic prev_clk = 1'b0;

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at cyc %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  task automatic push(input int kind, input int c, input int fac);
    ev_t e;
    e.kind = kind; e.cyc = c; e.fac = fac;
    exp_q.push_back(e);
  endtask

  // One full period whose tick appears at cycle t with half-period f.
  task automatic push_period(input int t, input int f);
    push(0, t, f);
    push(1, t + f, f);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) step(1);
  endtask

  always @(negedge clk_in) begin
    int  ev;
    ev_t e;
    if (!rst_n) begin
      prev_clk = 1'b0;
    end else begin
      ev = -1;
      if (done) ev = 2;
      else if (tick) ev = 0;
      else if (prev_clk && !clk_out) ev = 1;
      prev_clk = clk_out;
      if (ev >= 0) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_event: kind %0d at cyc %0d, expected none", ev, cyc);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind", ev, e.kind);
          chk("event_cyc", cyc, e.cyc);
          if (ev == 0) chk("tick_factor", int'(factor_active), e.fac);
        end
      end
    end
  end

  initial begin
    int s;
    rst_n = 1'b0; cfg_factor = '0; cfg_valid = 1'b0;
    start = 1'b0; stop = 1'b0; burst_len = '0;
    step(3);
    rst_n = 1'b1;
    step(1);

    // Reset state
    chk("rst_clk_out", clk_out, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_factor", int'(factor_active), 5);

    // Burst of 3 periods at factor 5
    s = cyc;
    push_period(s + 1, 5); push_period(s + 11, 5); push_period(s + 21, 5);
    push(2, s + 31, 5);
    burst_len = 16'd3; start = 1'b1; step(1); start = 1'b0;
    step(2);
    chk("burst_busy", busy, 1);
    chk("burst_clk_high", clk_out, 1);
    wait_until(s + 35);
    chk("burst_end_clk", clk_out, 0);
    chk("burst_end_busy", busy, 0);
    chk("burst_q_empty", exp_q.size(), 0);

    // Continuous run, factor 2 requested in cycle 2 of the first high phase
    s = cyc;
    push_period(s + 1, 5);
    push_period(s + 11, 2); push_period(s + 15, 2); push_period(s + 19, 2);
    push(2, s + 23, 2);
    burst_len = '0; start = 1'b1; step(1); start = 1'b0;
    cfg_factor = 8'd2; cfg_valid = 1'b1; step(1); cfg_valid = 1'b0;
    chk("pend_cfg_ready", cfg_ready, 0);
    wait_until(s + 10);
    chk("pend_hold_ready", cfg_ready, 0);
    chk("pend_hold_factor", int'(factor_active), 5);
    wait_until(s + 11);
    chk("applied_ready", cfg_ready, 1);
    chk("applied_factor", int'(factor_active), 2);
    wait_until(s + 20);
    stop = 1'b1; step(1); stop = 1'b0;
    wait_until(s + 26);
    chk("cont_busy", busy, 0);
    chk("cont_q_empty", exp_q.size(), 0);
    cfg_factor = 8'd5; cfg_valid = 1'b1; step(1); cfg_valid = 1'b0;
    chk("idle_cfg_factor", int'(factor_active), 5);

    // Stop in a high phase; a start in the done cycle must be ignored
    s = cyc;
    push_period(s + 1, 5); push_period(s + 11, 5);
    push(2, s + 21, 5);
    burst_len = '0; start = 1'b1; step(1); start = 1'b0;
    wait_until(s + 12);
    stop = 1'b1; step(1); stop = 1'b0;
    wait_until(s + 21);
    chk("stop_done", done, 1);
    start = 1'b1; step(1); start = 1'b0;
    wait_until(s + 30);
    chk("stop_busy", busy, 0);
    chk("stop_clk", clk_out, 0);
    chk("stop_q_empty", exp_q.size(), 0);

    // Zero factor in IDLE and in RUN is accepted and dropped
    cfg_factor = '0; cfg_valid = 1'b1; step(1); cfg_valid = 1'b0;
    chk("zero_idle_ready", cfg_ready, 1);
    chk("zero_idle_factor", int'(factor_active), 5);
    s = cyc;
    push_period(s + 1, 5);
    push(2, s + 11, 5);
    burst_len = 16'd1; start = 1'b1; step(1); start = 1'b0;
    cfg_factor = '0; cfg_valid = 1'b1; step(1); cfg_valid = 1'b0;
    chk("zero_run_ready", cfg_ready, 1);
    wait_until(s + 14);
    chk("zero_run_factor", int'(factor_active), 5);
    chk("zero_q_empty", exp_q.size(), 0);

    // Async reset in mid high phase, then a single clean period
    s = cyc;
    push(0, s + 1, 5);
    burst_len = 16'd4; start = 1'b1; step(1); start = 1'b0;
    wait_until(s + 3);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clk_out", clk_out, 0);
    chk("async_busy", busy, 0);
    step(2);
    rst_n = 1'b1;
    chk("post_rst_factor", int'(factor_active), 5);
    chk("post_rst_ready", cfg_ready, 1);
    step(1);
    s = cyc;
    push_period(s + 1, 5);
    push(2, s + 11, 5);
    burst_len = 16'd1; start = 1'b1; step(1); start = 1'b0;
    wait_until(s + 14);
    chk("single_busy", busy, 0);
    chk("single_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
